// File: rtl/temporal_encoder_pkg.sv
// Shared types and helpers for the temporal encoder array.
// Optional out_spike port is enabled by TEMPORAL_ENCODER_SPIKE_OUT_EN.
package temporal_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } enc_state_e;

    function automatic int value_width(input int max_value);
        value_width = (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int unsigned clamp_value(input int unsigned value,
                                                input int unsigned max_value);
        clamp_value = (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/temporal_encoder_channel.sv
// One encoder lane: holds a clamped value and registers its line level against the shared slot.
// Optional out_spike port is enabled by TEMPORAL_ENCODER_SPIKE_OUT_EN.
module temporal_encoder_channel
    import temporal_encoder_pkg::*;
#(
    parameter int MAX_VALUE    = 8,
    parameter int W            = value_width(MAX_VALUE),
    parameter bit EDGE_FALLING = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] in_value,
    input  logic         run_next,
    input  logic [W-1:0] slot_next,
    output logic         out_line
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
    ,
    output logic         out_spike
`endif
);

    localparam logic PRE_LVL  = EDGE_FALLING ? 1'b1 : 1'b0;
    localparam logic POST_LVL = EDGE_FALLING ? 1'b0 : 1'b1;

    logic [W-1:0] value_r;
    logic [W-1:0] value_s;
    logic [W-1:0] edge_slot_s;
    logic         line_s;

    // Outputs are registered, so compare against the value and slot the next cycle will hold.
    always_comb begin
        value_s = value_r;
        line_s  = POST_LVL;
        if (load) begin
            value_s = W'(clamp_value(32'(in_value), MAX_VALUE));
        end else begin
            value_s = value_r;
        end
        edge_slot_s = W'(MAX_VALUE) - value_s;
        if (run_next) begin
            line_s = (slot_next < edge_slot_s) ? PRE_LVL : POST_LVL;
        end else begin
            line_s = POST_LVL;
        end
    end

    // Value holder and registered line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_r  <= {W{1'b0}};
            out_line <= POST_LVL;
        end else begin
            value_r  <= value_s;
            out_line <= line_s;
        end
    end

`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
    logic spike_s;

    // Spike marks the single slot where the line changes level.
    always_comb begin
        spike_s = 1'b0;
        if (run_next) begin
            spike_s = (slot_next == edge_slot_s);
        end else begin
            spike_s = 1'b0;
        end
    end

    // Registered spike pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_spike <= 1'b0;
        end else begin
            out_spike <= spike_s;
        end
    end
`endif

endmodule

// File: rtl/temporal_encoder_array.sv
// Multi-channel race-logic encoder: larger value -> earlier edge inside a framed window.
// Optional out_spike port is enabled by TEMPORAL_ENCODER_SPIKE_OUT_EN.
module temporal_encoder_array
    import temporal_encoder_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_VALUE    = 8,
    parameter int GAP_CYCLES   = 2,
    parameter bit EDGE_FALLING = 1'b1
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_CHANNELS*value_width(MAX_VALUE)-1:0]  in_data,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    output logic [NUM_CHANNELS-1:0]                         out_line,
    output logic                                            window_start,
    output logic                                            busy
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
    ,
    output logic [NUM_CHANNELS-1:0]                         out_spike
`endif
);

    localparam int W        = value_width(MAX_VALUE);
    localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam bit HAS_GAP  = (GAP_CYCLES > 0);

    localparam logic [W-1:0]  SLOT_LAST  = W'(MAX_VALUE);
    localparam logic [GW-1:0] GAP_LAST_V = GW'(GAP_LAST);

    enc_state_e    state_r;
    enc_state_e    state_s;
    logic [W-1:0]  slot_r;
    logic [W-1:0]  slot_s;
    logic [GW-1:0] gap_r;
    logic [GW-1:0] gap_s;
    logic          xfer_s;
    logic          ready_s;
    logic          window_start_r;
    logic          busy_r;

    // Acceptance window: idle, last slot of a gapless frame, or the last gap cycle.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else if ((state_r == RUN) && (slot_r == SLOT_LAST) && !HAS_GAP) begin
            ready_s = 1'b1;
        end else if ((state_r == GAP) && (gap_r == GAP_LAST_V)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        xfer_s = in_valid && ready_s;
    end

    assign in_ready = ready_s;

    // Next-state, slot and gap counter logic.
    always_comb begin
        state_s = state_r;
        slot_s  = slot_r;
        gap_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_s = RUN;
                    slot_s  = {W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (slot_r == SLOT_LAST) begin
                    if (HAS_GAP) begin
                        state_s = GAP;
                        gap_s   = {GW{1'b0}};
                    end else if (xfer_s) begin
                        state_s = RUN;
                        slot_s  = {W{1'b0}};
                    end else begin
                        state_s = IDLE;
                        slot_s  = {W{1'b0}};
                    end
                end else begin
                    slot_s = slot_r + W'(1);
                end
            end
            GAP: begin
                if (gap_r == GAP_LAST_V) begin
                    gap_s = {GW{1'b0}};
                    slot_s = {W{1'b0}};
                    if (xfer_s) begin
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    gap_s = gap_r + GW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                slot_s  = {W{1'b0}};
                gap_s   = {GW{1'b0}};
            end
        endcase
    end

    // FSM state, counters and registered status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            slot_r         <= {W{1'b0}};
            gap_r          <= {GW{1'b0}};
            window_start_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            slot_r         <= slot_s;
            gap_r          <= gap_s;
            window_start_r <= xfer_s;
            busy_r         <= (state_s != IDLE);
        end
    end

    assign window_start = window_start_r;
    assign busy         = busy_r;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        temporal_encoder_channel #(
            .MAX_VALUE   (MAX_VALUE),
            .W           (W),
            .EDGE_FALLING(EDGE_FALLING)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .load     (xfer_s),
            .in_value (in_data[c*W +: W]),
            .run_next (state_s == RUN),
            .slot_next(slot_s),
            .out_line (out_line[c])
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
            ,
            .out_spike(out_spike[c])
`endif
        );
    end

endmodule

// File: tb/tb_temporal_encoder_array.sv
// Self-checking bench: a falling-edge/gap-2 instance and a rising-edge/gapless instance
// checked slot by slot against a value-to-edge-time reference model.
module tb_temporal_encoder_array;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data_a, in_data_b;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic [3:0]  line_a, line_b;
    logic        ws_a, ws_b, busy_a, busy_b;
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
    logic [3:0]  spike_a, spike_b;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_start = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    temporal_encoder_array #(
        .NUM_CHANNELS(4), .MAX_VALUE(8), .GAP_CYCLES(2), .EDGE_FALLING(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_line(line_a), .window_start(ws_a), .busy(busy_a)
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
        , .out_spike(spike_a)
`endif
    );

    temporal_encoder_array #(
        .NUM_CHANNELS(4), .MAX_VALUE(8), .GAP_CYCLES(0), .EDGE_FALLING(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_line(line_b), .window_start(ws_b), .busy(busy_b)
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
        , .out_spike(spike_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: clamp to 8, edge time = 8 - v, line is pre level strictly before it.
    function automatic logic [3:0] model_line(input int v[4], input int slot, input bit falling);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) begin
            int vc = (v[c] > 8) ? 8 : v[c];
            r[c] = (slot < (8 - vc)) ? falling : !falling;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_spike(input int v[4], input int slot);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) begin
            int vc = (v[c] > 8) ? 8 : v[c];
            r[c] = (slot == (8 - vc));
        end
        return r;
    endfunction

    function automatic logic [15:0] pack(input int v[4]);
        logic [15:0] r;
        for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(v[c]);
        return r;
    endfunction

    // Called at a negedge where the selected DUT is ready; returns at its next ready point.
    task automatic run_window(input bit sel, input int v[4], input bit keep_valid,
                              input bit churn, input int exp_period);
        bit falling = !sel;
        logic [3:0] ol;
        if (sel) begin
            in_data_b = pack(v); in_valid_b = 1'b1;
            chk("ready_at_transfer_b", 32'(in_ready_b), 32'd1);
        end else begin
            in_data_a = pack(v); in_valid_a = 1'b1;
            chk("ready_at_transfer_a", 32'(in_ready_a), 32'd1);
        end
        for (int s = 0; s <= 8; s++) begin
            @(negedge clock);
            if (s == 0) begin
                if (exp_period > 0) chk("window_period", 32'(cyc - last_start), 32'(exp_period));
                last_start = cyc;
            end
            if (!keep_valid) begin
                if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
            end
            if (churn && s >= 2 && s <= 4) begin
                if (sel) begin in_data_b = 16'($urandom); in_valid_b = 1'b1; end
                else begin in_data_a = 16'($urandom); in_valid_a = 1'b1; end
            end
            ol = sel ? line_b : line_a;
            chk($sformatf("line_slot%0d_%s", s, sel ? "b" : "a"), 32'(ol), 32'(model_line(v, s, falling)));
            chk("window_start_run", 32'(sel ? ws_b : ws_a), 32'(s == 0));
            chk("busy_run", 32'(sel ? busy_b : busy_a), 32'd1);
            chk("in_ready_run", 32'(sel ? in_ready_b : in_ready_a), 32'(sel && s == 8));
`ifdef TEMPORAL_ENCODER_SPIKE_OUT_EN
            chk("spike_run", 32'(sel ? spike_b : spike_a), 32'(model_spike(v, s)));
`endif
        end
        if (!sel) begin
            for (int g = 0; g < 2; g++) begin
                @(negedge clock);
                chk("line_gap", 32'(line_a), 32'd0);
                chk("window_start_gap", 32'(ws_a), 32'd0);
                chk("busy_gap", 32'(busy_a), 32'd1);
                chk("in_ready_gap", 32'(in_ready_a), 32'(g == 1));
            end
        end
    endtask

    initial begin
        int v[4];
        reset = 1'b0;
        in_data_a = 16'h0; in_data_b = 16'h0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_line_a", 32'(line_a), 32'h0);
        chk("reset_ready_a", 32'(in_ready_a), 32'd1);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_ws_a", 32'(ws_a), 32'd0);
        chk("reset_line_b", 32'(line_b), 32'hF);
        chk("reset_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed window {ch3=8, ch2=5, ch1=1, ch0=0} with mid-window input churn.
        v = '{0, 1, 5, 8};
        run_window(1'b0, v, 1'b0, 1'b1, 0);
        @(negedge clock);
        chk("idle_busy_a", 32'(busy_a), 32'd0);
        chk("idle_line_a", 32'(line_a), 32'h0);
        chk("idle_ready_a", 32'(in_ready_a), 32'd1);

        // Back-to-back with in_valid held high; first window exercises clamping of 15.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) v = '{15, 0, 3, 9};
            else for (int c = 0; c < 4; c++) v[c] = int'($urandom_range(0, 15));
            run_window(1'b0, v, 1'b1, 1'b0, (i == 0) ? 0 : 11);
        end
        in_valid_a = 1'b0;
        @(negedge clock);
        chk("idle_after_b2b", 32'(busy_a), 32'd0);

        // Random isolated windows with random idle spacing.
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) v[c] = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_window(1'b0, v, 1'b0, 1'b0, 0);
        end

        // Reset asserted in slot 3 abandons the window at once.
        @(negedge clock);
        v = '{2, 6, 7, 4};
        in_data_a = pack(v); in_valid_a = 1'b1;
        @(negedge clock);
        in_valid_a = 1'b0;
        repeat (3) @(negedge clock);
        chk("line_slot3_pre_reset", 32'(line_a), 32'(model_line(v, 3, 1'b1)));
        reset = 1'b0;
        #1;
        chk("abort_line", 32'(line_a), 32'h0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_ws", 32'(ws_a), 32'd0);
        chk("abort_ready", 32'(in_ready_a), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        v = '{8, 3, 0, 5};
        run_window(1'b0, v, 1'b0, 1'b0, 0);

        // Rising-edge, gapless instance: value 4 rises at slot 4, windows every 9 cycles.
        chk("idle_line_b", 32'(line_b), 32'hF);
        v = '{4, 0, 8, 2};
        run_window(1'b1, v, 1'b1, 1'b0, 0);
        for (int c = 0; c < 4; c++) v[c] = int'($urandom_range(0, 15));
        run_window(1'b1, v, 1'b1, 1'b0, 9);
        for (int c = 0; c < 4; c++) v[c] = int'($urandom_range(0, 15));
        run_window(1'b1, v, 1'b0, 1'b0, 9);
        @(negedge clock);
        chk("idle_busy_b", 32'(busy_b), 32'd0);
        chk("idle_line_b_end", 32'(line_b), 32'hF);
        chk("idle_ws_b", 32'(ws_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
